// File: rtl/cell_write_allocator_pkg.sv
// Shared switch types: cell info flags, written-cell record and free-list state.
// Record fields are sized for the largest supported configuration; narrower designs zero-extend.
package genericSwitchPkg;

  localparam int unsigned PORT_FIELD_WIDTH    = 4;
  localparam int unsigned ADDRESS_FIELD_WIDTH = 10;

  typedef struct packed {
    logic sof;
    logic eof;
  } info_type;

  typedef struct packed {
    logic [PORT_FIELD_WIDTH-1:0]    port;
    logic [ADDRESS_FIELD_WIDTH-1:0] address;
    info_type                       info;
  } cell_queue_type;

  typedef enum logic {
    INIT,
    RUN
  } free_list_state_type;

  // A SOF cell pops its own address; any non-EOF cell pops the link to its successor.
  function automatic logic [1:0] cell_need(input logic sof, input logic eof);
    return {1'b0, sof} + {1'b0, ~eof};
  endfunction

endpackage

// File: rtl/cell_write_allocator_free_list.sv
// Circular free-address list: self-initialises to 0..addresses-1, then serves
// up to two pops and one push per cycle, flagging pushes into a full list.
module free_address_list
  import genericSwitchPkg::*;
#(
  parameter int unsigned addresses    = 32,
  parameter int unsigned addressWidth = $clog2(addresses)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [1:0]              pop_count,
  input  logic                    push,
  input  logic [addressWidth-1:0] push_address,
  output logic [addressWidth-1:0] head_first,
  output logic [addressWidth-1:0] head_second,
  output logic [addressWidth:0]   count,
  output logic                    init_done,
  output logic                    overflow
);

  localparam logic [addressWidth-1:0] LAST = addressWidth'(addresses - 1);
  localparam logic [addressWidth:0]   FULL = (addressWidth + 1)'(addresses);

  free_list_state_type state, state_next;

  logic [addressWidth-1:0] slots [addresses];
  logic [addressWidth-1:0] head, tail, head_next;
  logic [addressWidth-1:0] head_plus1, head_plus2, tail_plus1;
  logic [addressWidth:0]   count_next;
  logic                    wr_en;
  logic [addressWidth-1:0] wr_data;
  logic                    pushing;

  function automatic logic [addressWidth-1:0] wrap_inc(input logic [addressWidth-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign head_plus1  = wrap_inc(head);
  assign head_plus2  = wrap_inc(head_plus1);
  assign tail_plus1  = wrap_inc(tail);
  assign head_first  = slots[head];
  assign head_second = slots[head_plus1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == INIT && tail == LAST) state_next = RUN;
  end

  // During INIT the tail pointer doubles as the initialisation counter.
  always_comb begin
    wr_en      = 1'b0;
    wr_data    = '0;
    pushing    = 1'b0;
    overflow   = 1'b0;
    head_next  = head;
    count_next = count;
    init_done  = 1'b0;
    case (state)
      INIT: begin
        wr_en      = 1'b1;
        wr_data    = tail;
        count_next = count + 1'b1;
      end
      RUN: begin
        init_done  = 1'b1;
        pushing    = push && (count != FULL);
        overflow   = push && (count == FULL);
        wr_en      = pushing;
        wr_data    = push_address;
        head_next  = (pop_count == 2'd2) ? head_plus2 :
                     (pop_count == 2'd1) ? head_plus1 : head;
        count_next = count - (addressWidth + 1)'(pop_count) + (addressWidth + 1)'(pushing);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      count <= count_next;
      if (wr_en) tail <= tail_plus1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) slots[tail] <= wr_data;
  end

endmodule

// File: rtl/cell_write_allocator.sv
// Round-robin cell write allocator: grants one input cell per cycle, links frame
// cells through free-list addresses and writes them into cell memory one cycle later.
module cell_write_allocator
  import genericSwitchPkg::*;
#(
  parameter int unsigned nbrOfPorts     = 1,
  parameter int unsigned addresses      = 32,
  parameter int unsigned parrallelWidth = 512,
  parameter int unsigned addressWidth   = $clog2(addresses)
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic [nbrOfPorts-1:0]                    cellValid,
  input  logic [nbrOfPorts-1:0]                    cellSof,
  input  logic [nbrOfPorts-1:0]                    cellEof,
  input  logic [nbrOfPorts-1:0][parrallelWidth-1:0] cellData,
  output logic [nbrOfPorts-1:0]                    cellReady,
  output logic                                     memWriteEnable,
  output logic [addressWidth-1:0]                  memWriteAddress,
  output logic [parrallelWidth-1:0]                memWriteData,
  output info_type                                 memWriteInfo,
  output logic [addressWidth-1:0]                  memWriteNextPtr,
  output logic                                     wroteCell,
  output cell_queue_type                           writtenCell,
  input  logic                                     freeEnable,
  input  logic [addressWidth-1:0]                  freeAddress,
  output logic [addressWidth:0]                    freeCount,
  output logic                                     initDone,
  output logic                                     protoError
);

  localparam int unsigned PW        = (nbrOfPorts > 1) ? $clog2(nbrOfPorts) : 1;
  localparam logic [PW-1:0] LAST_PORT = PW'(nbrOfPorts - 1);

  logic [nbrOfPorts-1:0]   in_frame, violation, candidate;
  logic [addressWidth-1:0] reserved [nbrOfPorts];
  logic [PW-1:0]           rr, win;
  logic                    found;
  logic                    win_sof, win_eof, win_violation;
  logic [addressWidth-1:0] head_first, head_second, own_addr, next_addr;
  logic [1:0]              pop_count;
  logic                    list_overflow;
  logic                    write_now;

  function automatic logic [PW-1:0] port_add(input logic [PW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= nbrOfPorts) s = s - nbrOfPorts;
    return PW'(s);
  endfunction

  free_address_list #(
    .addresses   (addresses),
    .addressWidth(addressWidth)
  ) u_free_list (
    .clk         (clk),
    .rstn        (rstn),
    .pop_count   (pop_count),
    .push        (freeEnable),
    .push_address(freeAddress),
    .head_first  (head_first),
    .head_second (head_second),
    .count       (freeCount),
    .init_done   (initDone),
    .overflow    (list_overflow)
  );

  // Framing violators need no addresses: they are always grantable so they can be discarded.
  always_comb begin
    violation = '0;
    candidate = '0;
    for (int unsigned i = 0; i < nbrOfPorts; i++) begin
      violation[i] = cellSof[i] ? in_frame[i] : !in_frame[i];
      candidate[i] = initDone && cellValid[i] &&
                     (violation[i] ||
                      freeCount >= (addressWidth + 1)'(cell_need(cellSof[i], cellEof[i])));
    end
  end

  always_comb begin
    found = 1'b0;
    win   = rr;
    for (int unsigned k = 0; k < nbrOfPorts; k++) begin
      if (!found && candidate[port_add(rr, k)]) begin
        found = 1'b1;
        win   = port_add(rr, k);
      end
    end
  end

  always_comb begin
    cellReady = '0;
    for (int unsigned i = 0; i < nbrOfPorts; i++) begin
      cellReady[i] = found && (win == PW'(i));
    end
  end

  always_comb begin
    win_sof       = cellSof[win];
    win_eof       = cellEof[win];
    win_violation = violation[win];
    own_addr      = win_sof ? head_first : reserved[win];
    next_addr     = win_sof ? head_second : head_first;
    write_now     = found && !win_violation;
    pop_count     = write_now ? cell_need(win_sof, win_eof) : 2'd0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr       <= '0;
      in_frame <= '0;
      for (int unsigned i = 0; i < nbrOfPorts; i++) reserved[i] <= '0;
    end else if (found) begin
      rr            <= (win == LAST_PORT) ? '0 : win + 1'b1;
      in_frame[win] <= win_eof ? 1'b0 : (win_sof ? 1'b1 : in_frame[win]);
      if (!win_violation && !win_eof) reserved[win] <= next_addr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      memWriteEnable  <= 1'b0;
      memWriteAddress <= '0;
      memWriteData    <= '0;
      memWriteInfo    <= '0;
      memWriteNextPtr <= '0;
      wroteCell       <= 1'b0;
      writtenCell     <= '0;
      protoError      <= 1'b0;
    end else begin
      memWriteEnable <= write_now;
      wroteCell      <= write_now;
      protoError     <= protoError || (found && win_violation) || list_overflow;
      if (write_now) begin
        memWriteAddress     <= own_addr;
        memWriteData        <= cellData[win];
        memWriteInfo        <= '{sof: win_sof, eof: win_eof};
        memWriteNextPtr     <= next_addr;
        writtenCell.port    <= PORT_FIELD_WIDTH'(win);
        writtenCell.address <= ADDRESS_FIELD_WIDTH'(own_addr);
        writtenCell.info    <= '{sof: win_sof, eof: win_eof};
      end
    end
  end

endmodule

// File: tb/tb_cell_write_allocator.sv
// Directed bench for cell_write_allocator with two ports, 32 addresses and 16-bit cells.
module tb_cell_write_allocator;
  import genericSwitchPkg::*;

  logic             clk = 1'b0;
  logic             rstn;
  logic [1:0]       cellValid, cellSof, cellEof;
  logic [1:0][15:0] cellData;
  logic [1:0]       cellReady;
  logic             memWriteEnable;
  logic [4:0]       memWriteAddress;
  logic [15:0]      memWriteData;
  info_type         memWriteInfo;
  logic [4:0]       memWriteNextPtr;
  logic             wroteCell;
  cell_queue_type   writtenCell;
  logic             freeEnable;
  logic [4:0]       freeAddress;
  logic [5:0]       freeCount;
  logic             initDone;
  logic             protoError;

  int errors = 0;
  int checks = 0;

  cell_write_allocator #(
    .nbrOfPorts    (2),
    .addresses     (32),
    .parrallelWidth(16)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cellValid      (cellValid),
    .cellSof        (cellSof),
    .cellEof        (cellEof),
    .cellData       (cellData),
    .cellReady      (cellReady),
    .memWriteEnable (memWriteEnable),
    .memWriteAddress(memWriteAddress),
    .memWriteData   (memWriteData),
    .memWriteInfo   (memWriteInfo),
    .memWriteNextPtr(memWriteNextPtr),
    .wroteCell      (wroteCell),
    .writtenCell    (writtenCell),
    .freeEnable     (freeEnable),
    .freeAddress    (freeAddress),
    .freeCount      (freeCount),
    .initDone       (initDone),
    .protoError     (protoError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] s, input logic [1:0] e,
                       input logic [15:0] d0, input logic [15:0] d1);
    cellValid   = v;
    cellSof     = s;
    cellEof     = e;
    cellData[0] = d0;
    cellData[1] = d1;
  endtask

  task automatic reset_and_init(input logic hold_valid);
    int n;
    rstn        = 1'b0;
    freeEnable  = 1'b0;
    freeAddress = '0;
    if (hold_valid) drive(2'b01, 2'b01, 2'b01, 16'h1111, 16'h0);
    else            drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    #2;
    check("rst_freeCount", freeCount, 0);
    check("rst_initDone", initDone, 0);
    check("rst_memWriteEnable", memWriteEnable, 0);
    check("rst_wroteCell", wroteCell, 0);
    check("rst_writtenCell", writtenCell, 0);
    check("rst_protoError", protoError, 0);
    check("rst_cellReady", cellReady, 0);
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    while (!initDone && n < 100) begin
      tick();
      n++;
      if (!initDone && hold_valid) check("init_no_ready", cellReady, 0);
    end
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    check("init_cycles", n, 32);
    check("init_freeCount", freeCount, 32);
  endtask

  initial begin
    reset_and_init(1'b1);

    // Single SOF+EOF cell on port 0
    drive(2'b01, 2'b01, 2'b01, 16'hCAFE, 16'h0);
    #1;
    check("single_ready", cellReady, 2'b01);
    tick();
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    check("single_we", memWriteEnable, 1);
    check("single_addr", memWriteAddress, 0);
    check("single_data", memWriteData, 16'hCAFE);
    check("single_info", memWriteInfo, 2'b11);
    check("single_wrote", wroteCell, 1);
    check("single_wc_port", writtenCell.port, 0);
    check("single_wc_addr", writtenCell.address, 0);
    check("single_freeCount", freeCount, 31);
    tick();
    check("single_we_after", memWriteEnable, 0);

    // Three-cell frame on port 0 from a fresh list
    reset_and_init(1'b0);
    drive(2'b01, 2'b01, 2'b00, 16'h0A01, 16'h0);
    #1;
    check("frame1_ready", cellReady, 2'b01);
    tick();
    check("frame1_addr", memWriteAddress, 0);
    check("frame1_next", memWriteNextPtr, 1);
    check("frame1_info", memWriteInfo, 2'b10);
    check("frame1_freeCount", freeCount, 30);
    drive(2'b01, 2'b00, 2'b00, 16'h0A02, 16'h0);
    #1;
    check("frame2_ready", cellReady, 2'b01);
    tick();
    check("frame2_addr", memWriteAddress, 1);
    check("frame2_next", memWriteNextPtr, 2);
    check("frame2_info", memWriteInfo, 2'b00);
    check("frame2_data", memWriteData, 16'h0A02);
    check("frame2_freeCount", freeCount, 29);
    drive(2'b01, 2'b00, 2'b01, 16'h0A03, 16'h0);
    #1;
    tick();
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    check("frame3_we", memWriteEnable, 1);
    check("frame3_addr", memWriteAddress, 2);
    check("frame3_info", memWriteInfo, 2'b01);
    check("frame3_freeCount", freeCount, 29);
    check("frame_protoError", protoError, 0);

    // Both ports streaming single-cell frames: last grant was port 0, so port 1 leads
    drive(2'b11, 2'b11, 2'b11, 16'hA000, 16'hB000);
    #1;
    for (int g = 0; g < 6; g++) begin
      check("rr_ready", cellReady, (g % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      check("rr_port", writtenCell.port, (g % 2 == 0) ? 1 : 0);
      check("rr_addr", memWriteAddress, 3 + g);
      check("rr_data", memWriteData, (g % 2 == 0) ? 16'hB000 : 16'hA000);
      #1;
    end
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    #1;
    check("rr_freeCount", freeCount, 23);
    check("rr_idle_ready", cellReady, 2'b00);

    // Exhaust the list down to one entry, then stall a two-address cell until a free arrives
    reset_and_init(1'b0);
    for (int i = 0; i < 31; i++) begin
      drive(2'b01, 2'b01, 2'b01, 16'(i), 16'h0);
      tick();
    end
    check("exh_freeCount", freeCount, 1);
    check("exh_last_addr", memWriteAddress, 30);
    drive(2'b01, 2'b01, 2'b00, 16'h5EED, 16'h0);
    #1;
    check("stall_ready", cellReady, 2'b00);
    tick();
    check("stall_ready2", cellReady, 2'b00);
    check("stall_nowrite", wroteCell, 0);
    freeEnable  = 1'b1;
    freeAddress = 5'd5;
    #1;
    check("stall_during_push", cellReady, 2'b00);
    tick();
    freeEnable = 1'b0;
    check("push_freeCount", freeCount, 2);
    #1;
    check("unstall_ready", cellReady, 2'b01);
    tick();
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    check("unstall_addr", memWriteAddress, 31);
    check("unstall_next", memWriteNextPtr, 5);
    check("unstall_info", memWriteInfo, 2'b10);
    check("unstall_freeCount", freeCount, 0);

    // Reset mid-frame: port 0 must accept a fresh SOF without a framing error
    reset_and_init(1'b0);
    drive(2'b01, 2'b01, 2'b01, 16'h7777, 16'h0);
    #1;
    check("postrst_ready", cellReady, 2'b01);
    tick();
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    check("postrst_addr", memWriteAddress, 0);
    check("postrst_protoError", protoError, 0);
    freeEnable  = 1'b1;
    freeAddress = 5'd0;
    tick();
    check("refill_freeCount", freeCount, 32);
    check("refill_protoError", protoError, 0);
    freeAddress = 5'd3;
    tick();
    freeEnable = 1'b0;
    check("overflow_protoError", protoError, 1);
    check("overflow_freeCount", freeCount, 32);

    // Non-SOF cell on an idle port is consumed but not written
    reset_and_init(1'b0);
    drive(2'b10, 2'b00, 2'b00, 16'h0, 16'hDEAD);
    #1;
    check("drop_ready", cellReady, 2'b10);
    tick();
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    check("drop_wrote", wroteCell, 0);
    check("drop_we", memWriteEnable, 0);
    check("drop_protoError", protoError, 1);
    check("drop_freeCount", freeCount, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
